// File: rtl/arb_pkg.sv
// Shared encodings for the round-robin decode arbiter: FSM state constants and release causes.
package arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic [1:0] {
        REL_NONE    = 2'd0,
        REL_DONE    = 2'd1,
        REL_DROP    = 2'd2,
        REL_TIMEOUT = 2'd3
    } rel_cause_e;

endpackage

// File: rtl/rr_decode_arbiter_dec.sv
// Index-to-one-hot decoder with enable; all-zero output when disabled.
module idx_onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]      idx,
    input  logic              en,
    output logic [(1<<N)-1:0] onehot
);

    localparam int R = 1 << N;

    assign onehot = en ? (R'(1) << idx) : '0;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 2**N requesters with registered one-hot grant.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_decode_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [(1<<N)-1:0] req,
    input  logic              done,
    output logic [(1<<N)-1:0] gnt,
    output logic [N-1:0]      gnt_idx,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam int R = 1 << N;

    logic          state_q, state_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [N-1:0]  gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;
    logic [R-1:0]  gnt_q, gnt_d;
    logic          win_found;
    logic [N-1:0]  win_idx;
    logic [N-1:0]  cand;
    logic          hold_hit;
    rel_cause_e    cause;

    // Scan downward in offset so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = R - 1; k >= 0; k--) begin
            cand = ptr_q + N'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;

    assign hold_hit = (hold_q == HW'(MAX_HOLD - 1));

    // Counter restarts on each grant and holds its value once the owner is released.
    always_comb begin
        hold_d = hold_q;
        if (state_q == ST_IDLE && enable && win_found) begin
            hold_d = '0;
        end else if (state_q == ST_BUSY && cause == REL_NONE) begin
            hold_d = hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    assign hold_hit = 1'b0;
`endif

    // A done strobe or owner drop takes priority, so only a lone expiry reports a timeout.
    always_comb begin
        cause = REL_NONE;
        if (state_q == ST_BUSY) begin
            if (done)                  cause = REL_DONE;
            else if (!req[gnt_idx_q])  cause = REL_DROP;
            else if (hold_hit)         cause = REL_TIMEOUT;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable && win_found) begin
                state_d     = ST_BUSY;
                gnt_idx_d   = win_idx;
                gnt_valid_d = 1'b1;
            end else begin
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        end else if (cause != REL_NONE) begin
            state_d     = ST_IDLE;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            ptr_d       = gnt_idx_q + N'(1);
            timeout_d   = (cause == REL_TIMEOUT);
        end
    end

    idx_onehot_dec #(.N(N)) u_dec (
        .idx    (gnt_idx_d),
        .en     (gnt_valid_d),
        .onehot (gnt_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            gnt_q       <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter with a cycle-level behavioural reference model.
module tb_rr_decode_arbiter;

    localparam int N        = 3;
    localparam int R        = 1 << N;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [R-1:0] req = '0;
    logic         done = 1'b0;
    logic [R-1:0] gnt;
    logic [N-1:0] gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    rr_decode_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner is -1 when nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (enable && req != '0) begin
                for (int k = 0; k < R; k++) begin
                    if (req[(m_ptr + k) % R]) begin
                        m_owner = (m_ptr + k) % R;
                        break;
                    end
                end
                m_hold = 0;
            end
        end else begin
            bit drop, expired;
            drop    = !req[m_owner];
            expired = TO_EN && (m_hold == MAX_HOLD - 1);
            if (done || drop || expired) begin
                m_ptr   = (m_owner + 1) % R;
                m_to    = expired && !done && !drop;
                m_owner = -1;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_gnt",   32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("model_idx",   32'(gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
            check("model_to",    32'(timeout),   32'(m_to));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done;
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        int cnt;
        bit rel;
        step();
        step();
        check("reset_gnt",   32'(gnt),       32'd0);
        check("reset_valid", 32'(gnt_valid), 32'd0);
        check("reset_to",    32'(timeout),   32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // single request then done
        req = 8'b0000_0100; enable = 1'b1;
        step();
        check("single_gnt",   32'(gnt),       32'h04);
        check("single_idx",   32'(gnt_idx),   32'd2);
        check("single_valid", 32'(gnt_valid), 32'd1);
        pulse_done();
        check("single_rel", 32'(gnt), 32'd0);
        req = 8'b0000_1100;
        step();
        check("ptr3_idx", 32'(gnt_idx), 32'd3);
        req = '0;
        step();
        check("drop_rel", 32'(gnt_valid), 32'd0);

        // fairness from ptr 0
        reset = 1'b1; step(); reset = 1'b0;
        req = 8'hFF;
        for (int i = 0; i <= R; i++) begin
            step();
            check("rr_idx", 32'(gnt_idx), 32'(i % R));
            pulse_done();
            check("rr_gap", 32'(gnt_valid), 32'd0);
        end

        // wrap search after a grant to 5
        req = 8'b0010_0000;
        step();
        check("w5_idx", 32'(gnt_idx), 32'd5);
        pulse_done();
        req = 8'b0000_0011;
        step();
        check("wrap0_idx", 32'(gnt_idx), 32'd0);
        pulse_done();
        req = 8'b0000_0010;
        step();
        check("wrap1_idx", 32'(gnt_idx), 32'd1);
        done = 1'b1; req = '0;
        step();
        done = 1'b0;

        // enable low holds the current grant, blocks new ones
        req = 8'b0001_0000;
        step();
        check("en_idx", 32'(gnt_idx), 32'd4);
        enable = 1'b0;
        step(); step(); step();
        check("en_hold", 32'(gnt), 32'h10);
        req = '0;
        step();
        check("en_drop", 32'(gnt_valid), 32'd0);
        req = 8'hFF;
        step(); step();
        check("en_block", 32'(gnt_valid), 32'd0);

        // forced release
        enable = 1'b1; req = 8'b1000_0000;
        step();
        check("to_idx", 32'(gnt_idx), 32'd7);
        cnt = 0; rel = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (!gnt_valid) begin
                rel = 1'b1;
                break;
            end
            cnt++;
            step();
        end
`ifdef ARB_TIMEOUT_EN
        check("to_cycles", 32'(cnt),     32'(MAX_HOLD));
        check("to_rel",    32'(rel),     32'd1);
        check("to_pulse",  32'(timeout), 32'd1);
`else
        check("nto_cycles", 32'(cnt),     32'd12);
        check("nto_rel",    32'(rel),     32'd0);
        check("nto_pulse",  32'(timeout), 32'd0);
        pulse_done();
`endif
        req = 8'b1000_0001;
        step();
        check("to_ptr0", 32'(gnt_idx), 32'd0);
        check("to_once", 32'(timeout), 32'd0);
        done = 1'b1; req = '0;
        step();
        done = 1'b0;

        // reset mid-grant
        req = 8'b0001_0000;
        step();
        check("mid_gnt", 32'(gnt), 32'h10);
        reset = 1'b1;
        step();
        check("mid_rst_gnt", 32'(gnt),       32'd0);
        check("mid_rst_val", 32'(gnt_valid), 32'd0);
        reset = 1'b0; req = 8'hFF;
        step();
        check("mid_ptr0", 32'(gnt_idx), 32'd0);
        pulse_done();
        step();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource among 2**N requesters.
- Grant is carried as an N-bit index and expanded to a one-hot grant vector by an index-to-one-hot decode stage with enable.
- Sits between requesting channel blocks and the shared resource; the owner holds the grant until it releases it or is timed out.

Parameters:
- N, 3, index width; requester count is 2**N.
- MAX_HOLD, 16, maximum grant-held cycles before forced release (used only with ARB_TIMEOUT_EN); must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  arbitration enable; low blocks new grants
- req  input  2**N  request vector, one bit per requester
- done  input  1  release strobe from current owner
- gnt  output  2**N  one-hot grant; all zero when no owner
- gnt_idx  output  N  index of current owner; 0 when idle
- gnt_valid  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- All outputs and state are registered. On reset: state IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, pointer ptr=0, hold counter=0.
- Reset mid-grant: the grant is dropped at that edge with no release handshake.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If enable=1 and req!=0, select the first set req bit searching upward from ptr, wrapping mod 2**N.
  - Next edge: state BUSY, gnt_idx=winner, gnt_valid=1, gnt=one-hot(winner), hold counter=0.
  - Latency: req asserted at edge t gives gnt visible after edge t+1.
  - If enable=0 or req=0, stay IDLE with outputs 0.
- BUSY: release is triggered by any of:
  - done=1;
  - req[gnt_idx]=0;
  - hold counter == MAX_HOLD-1 (timeout build only).
- On release, next edge:
  - state IDLE, gnt=0, gnt_valid=0;
  - ptr = (gnt_idx+1) mod 2**N, wrapping from 2**N-1 to 0;
  - timeout pulses for one cycle only when the release cause was timeout alone.
- There is always one idle cycle between consecutive grants, so gnt_valid drops for at least one cycle.
- enable going low during BUSY does not revoke the current grant; it only blocks the next one.
- done asserted in IDLE is ignored.
- Requests changing during BUSY do not affect the owner, except the owner's own req bit.
- Simultaneous done and timeout count as a normal release, with timeout=0.
- gnt is always exactly one-hot when gnt_valid=1, and all-zero otherwise.
- Search is purely combinational over 2**N bits. No request is starved: it waits at most 2**N-1 other grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: the hold counter, the MAX_HOLD forced release and the timeout pulse are present. The counter increments each BUSY cycle and saturates at release.
- Undefined: no counter logic; release happens only via done or the owner dropping req; timeout is tied to 0.

Decomposition:
- Shared package arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - release-cause encoding (REL_DONE, REL_DROP, REL_TIMEOUT).
- One natural sub-module, idx_onehot_dec: parameter N, inputs idx[N-1:0] and en, output onehot[2**N-1:0] = en ? 1<<idx : 0. It is driven by gnt_idx and the next-state valid bit, then registered.

Test Plan:
- Reset then single request: req=8'b0000_0100, enable=1 -> one cycle later gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1; done pulse -> next cycle gnt=0, ptr=3.
- Round-robin fairness: req=8'hFF held, done pulsed each grant -> gnt_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
- Wrap search: ptr=6 after a grant to 5, req=8'b0000_0011 -> grant idx 0, then idx 1.
- Owner drop and enable: owner drops req -> release next edge. enable=0 during BUSY -> grant held; with enable=0 in IDLE and req=8'hFF -> no grant.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'b1000_0000 held, no done -> gnt_valid high for exactly 4 cycles, timeout pulses once, ptr=0.
- Reset mid-grant: reset asserted while gnt=8'b0001_0000 -> next edge all outputs 0, ptr=0; req=8'hFF afterward -> grant idx 0.
